// File: rtl/sram_arbiter.sv
// sram_arbiter: time-slot arbiter and strobe sequencer for the shared video/main
// SRAM port. Requesters (priority): video fetch, CPU, ULAplus palette.
// Ports: clk28/usrrst_n; video_req/addr -> video_ack/done; cpu_req/wr/addr/wdata
// -> cpu_done/cpu_wait; up_req_rd/wr/addr/wdata -> up_done; rd_data;
// SRAM side va, vd_out, vd_oe, vd_in, n_vrd, n_vwr.
// Build option: define SRAM_ARB_UP_EN to enable the palette requester.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 3
) (
  input  logic        clk28,
  input  logic        usrrst_n,
  input  logic        video_req,
  input  logic [18:0] video_addr,
  output logic        video_ack,
  output logic        video_done,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [18:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_done,
  output logic        cpu_wait,
  input  logic        up_req_rd,
  input  logic        up_req_wr,
  input  logic [18:0] up_addr,
  input  logic [7:0]  up_wdata,
  output logic        up_done,
  output logic [7:0]  rd_data,
  output logic [18:0] va,
  output logic [7:0]  vd_out,
  output logic        vd_oe,
  input  logic [7:0]  vd_in,
  output logic        n_vrd,
  output logic        n_vwr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} state_t;
  typedef enum logic [1:0] {OWN_VID, OWN_CPU, OWN_UP} owner_t;

  localparam logic [2:0] AC = 3'(ACCESS_CYCLES);

  state_t      state;
  owner_t      owner;
  logic [2:0]  cnt;
  logic        last_vid;
  logic        cpu_busy;
  logic        up_done_q;

  logic        vid_pend, cpu_pend, up_pend;
  logic [18:0] vid_a, cpu_a, up_a;
  logic [7:0]  cpu_d, up_d;
  logic        cpu_w, up_w;

  logic        up_rd_s, up_wr_s;

`ifdef SRAM_ARB_UP_EN
  assign up_rd_s = up_req_rd;
  assign up_wr_s = up_req_wr;
  assign up_done = up_done_q;
`else
  logic up_unused;
  assign up_unused = up_req_rd ^ up_req_wr ^ up_done_q;
  assign up_rd_s   = 1'b0;
  assign up_wr_s   = 1'b0;
  assign up_done   = 1'b0;
`endif

  // CPU beats video whenever video had the previous slot.
  logic g_vid, g_cpu, g_up, idle;
  assign idle  = (state == IDLE);
  assign g_cpu = idle && cpu_pend && (last_vid || !vid_pend);
  assign g_vid = idle && vid_pend && !g_cpu;
  assign g_up  = idle && up_pend && !vid_pend && !cpu_pend;

  logic [18:0] va_sel;
  logic [7:0]  wd_sel;
  logic        wr_sel;
  owner_t      own_sel;

  always_comb begin
    va_sel  = vid_a;
    wd_sel  = cpu_d;
    wr_sel  = 1'b0;
    own_sel = OWN_VID;
    unique case (1'b1)
      g_cpu: begin
        va_sel  = cpu_a;
        wd_sel  = cpu_d;
        wr_sel  = cpu_w;
        own_sel = OWN_CPU;
      end
      g_up: begin
        va_sel  = up_a;
        wd_sel  = up_d;
        wr_sel  = up_w;
        own_sel = OWN_UP;
      end
      default: ;
    endcase
  end

  assign cpu_wait = cpu_pend | cpu_busy;

  always_ff @(posedge clk28 or negedge usrrst_n) begin
    if (!usrrst_n) begin
      state      <= IDLE;
      owner      <= OWN_VID;
      cnt        <= '0;
      last_vid   <= 1'b0;
      cpu_busy   <= 1'b0;
      vid_pend   <= 1'b0;
      cpu_pend   <= 1'b0;
      up_pend    <= 1'b0;
      vid_a      <= '0;
      cpu_a      <= '0;
      up_a       <= '0;
      cpu_d      <= '0;
      up_d       <= '0;
      cpu_w      <= 1'b0;
      up_w       <= 1'b0;
      video_ack  <= 1'b0;
      video_done <= 1'b0;
      cpu_done   <= 1'b0;
      up_done_q  <= 1'b0;
      rd_data    <= '0;
      va         <= '0;
      vd_out     <= '0;
      vd_oe      <= 1'b0;
      n_vrd      <= 1'b1;
      n_vwr      <= 1'b1;
    end else begin
      video_ack  <= 1'b0;
      video_done <= 1'b0;
      cpu_done   <= 1'b0;
      up_done_q  <= 1'b0;

      // A strobe in the grant cycle is a fresh request, so it wins.
      vid_pend <= video_req | (vid_pend & ~g_vid);
      cpu_pend <= cpu_req | (cpu_pend & ~g_cpu);
      up_pend  <= up_rd_s | up_wr_s | (up_pend & ~g_up);
      if (video_req) vid_a <= video_addr;
      if (cpu_req) begin
        cpu_a <= cpu_addr;
        cpu_d <= cpu_wdata;
        cpu_w <= cpu_wr;
      end
      if (up_rd_s || up_wr_s) begin
        up_a <= up_addr;
        up_d <= up_wdata;
        up_w <= up_wr_s;
      end

      unique case (state)
        IDLE: begin
          if (g_vid || g_cpu || g_up) begin
            va        <= va_sel;
            owner     <= own_sel;
            last_vid  <= g_vid;
            video_ack <= g_vid;
            if (g_cpu) cpu_busy <= 1'b1;
            if (wr_sel) begin
              state  <= WRITE;
              cnt    <= 3'd1;
              vd_oe  <= 1'b1;
              vd_out <= wd_sel;
            end else begin
              state <= READ;
              cnt   <= 3'd0;
            end
          end
        end
        READ: begin
          // First cycle is address setup; then AC cycles of n_vrd low.
          if (cnt == AC) begin
            rd_data    <= vd_in;
            n_vrd      <= 1'b1;
            state      <= IDLE;
            video_done <= (owner == OWN_VID);
            cpu_done   <= (owner == OWN_CPU);
            up_done_q  <= (owner == OWN_UP);
            cpu_busy   <= 1'b0;
          end else begin
            n_vrd <= 1'b0;
            cnt   <= cnt + 3'd1;
          end
        end
        WRITE: begin
          if (cnt == AC) begin
            n_vwr      <= 1'b1;
            state      <= TURN;
            cpu_done   <= (owner == OWN_CPU);
            up_done_q  <= (owner == OWN_UP);
            cpu_busy   <= 1'b0;
          end else begin
            n_vwr <= 1'b0;
            cnt   <= cnt + 3'd1;
          end
        end
        TURN: begin
          vd_oe <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter with a done-event scoreboard.
// Ports: none; drives every DUT port, clock clk28.
module tb_sram_arbiter;

  logic        clk28 = 1'b0;
  logic        usrrst_n;
  logic        video_req, video_ack, video_done;
  logic [18:0] video_addr;
  logic        cpu_req, cpu_wr, cpu_done, cpu_wait;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        up_req_rd, up_req_wr, up_done;
  logic [18:0] up_addr;
  logic [7:0]  up_wdata;
  logic [7:0]  rd_data, vd_out, vd_in;
  logic [18:0] va;
  logic        vd_oe, n_vrd, n_vwr;

  always #18 clk28 = ~clk28;

  sram_arbiter dut (
    .clk28(clk28), .usrrst_n(usrrst_n),
    .video_req(video_req), .video_addr(video_addr),
    .video_ack(video_ack), .video_done(video_done),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_done(cpu_done), .cpu_wait(cpu_wait),
    .up_req_rd(up_req_rd), .up_req_wr(up_req_wr),
    .up_addr(up_addr), .up_wdata(up_wdata), .up_done(up_done),
    .rd_data(rd_data), .va(va), .vd_out(vd_out), .vd_oe(vd_oe),
    .vd_in(vd_in), .n_vrd(n_vrd), .n_vwr(n_vwr)
  );

`ifdef SRAM_ARB_UP_EN
  localparam int UP_WR = 1;
`else
  localparam int UP_WR = 0;
`endif

  typedef struct {
    logic [1:0] who;
    logic       chk;
    logic [7:0] data;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  int          wr_cnt = 0;
  logic [18:0] wr_va = '0;
  logic [7:0]  wr_d = '0;
  logic        prev_nvwr = 1'b1;
  logic [1:0]  mon_who;
  exp_t        mon_e;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk28);
    #1;
  endtask

  task automatic push(input logic [1:0] w, input logic c,
                      input logic [7:0] d);
    exp_t e;
    e.who  = w;
    e.chk  = c;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic drain(input string tag, input int maxc);
    int g = 0;
    while (sbq.size() != 0 && g < maxc) begin
      tick();
      g++;
    end
    check(tag, 32'(sbq.size()), 32'd0);
    tick();
    tick();
  endtask

  // Scoreboard: every done pulse consumes the oldest expectation.
  always @(negedge clk28) begin
    if (usrrst_n && (video_done || cpu_done || up_done)) begin
      mon_who = video_done ? 2'd0 : (cpu_done ? 2'd1 : 2'd2);
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_unexpected_done observed=%0d expected=none",
               mon_who);
      end else begin
        mon_e = sbq.pop_front();
        check("sb_who", 32'(mon_who), 32'(mon_e.who));
        if (mon_e.chk)
          check("sb_rdata", 32'(rd_data), 32'(mon_e.data));
      end
    end
    if (usrrst_n && !n_vwr && prev_nvwr) wr_cnt++;
    if (!n_vwr) begin
      wr_va = va;
      wr_d  = vd_out;
    end
    prev_nvwr = n_vwr;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, g, last_v, w0;
    usrrst_n = 1'b0;
    video_req = 0; video_addr = '0;
    cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    up_req_rd = 0; up_req_wr = 0; up_addr = '0; up_wdata = '0;
    vd_in = '0;
    repeat (3) tick();

    check("rst_va", 32'(va), 32'd0);
    check("rst_vd_out", 32'(vd_out), 32'd0);
    check("rst_strobes", 32'({n_vrd, n_vwr, vd_oe}), 32'b110);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_pulses",
          32'({video_ack, video_done, cpu_done, up_done, cpu_wait}), 32'd0);
    usrrst_n = 1'b1;
    tick();

    // Video read, default access length.
    vd_in = 8'h3C;
    video_addr = 19'h1A5A5;
    video_req = 1'b1;
    push(2'd0, 1'b1, 8'h3C);
    tick();
    video_req = 1'b0;
    check("t1_ack_early", 32'(video_ack), 32'd0);
    tick();
    check("t1_ack", 32'(video_ack), 32'd1);
    check("t1_va", 32'(va), 32'h1A5A5);
    check("t1_nvrd_setup", 32'(n_vrd), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_nvrd_low", 32'(n_vrd), 32'd0);
      check("t1_done_early", 32'(video_done), 32'd0);
    end
    tick();
    check("t1_nvrd_rel", 32'(n_vrd), 32'd1);
    check("t1_done", 32'(video_done), 32'd1);
    check("t1_rd_data", 32'(rd_data), 32'h3C);
    tick();
    check("t1_done_pulse", 32'(video_done), 32'd0);

    // CPU write with turnaround.
    cpu_wr = 1'b1;
    cpu_addr = 19'h04000;
    cpu_wdata = 8'h77;
    cpu_req = 1'b1;
    push(2'd1, 1'b0, 8'h00);
    tick();
    cpu_req = 1'b0;
    check("t2_wait", 32'(cpu_wait), 32'd1);
    check("t2_oe_early", 32'(vd_oe), 32'd0);
    tick();
    check("t2_va", 32'(va), 32'h04000);
    check("t2_first", 32'({vd_oe, n_vwr}), 32'b11);
    check("t2_vd_out", 32'(vd_out), 32'h77);
    tick();
    check("t2_low1", 32'({vd_oe, n_vwr}), 32'b10);
    tick();
    check("t2_low2", 32'({vd_oe, n_vwr}), 32'b10);
    check("t2_vd_out_hold", 32'(vd_out), 32'h77);
    tick();
    check("t2_turn", 32'({n_vwr, vd_oe, cpu_done, cpu_wait}), 32'b1110);
    tick();
    check("t2_end", 32'({vd_oe, cpu_done}), 32'b00);
    tick();

    // Both requesters kept busy: grants must alternate.
    vd_in = 8'hA1;
    cpu_wr = 1'b0;
    video_addr = 19'h10000;
    cpu_addr = 19'h20000;
    for (int i = 0; i < 11; i++) push(2'(i % 2), 1'b1, 8'hA1);
    video_req = 1'b1;
    cpu_req = 1'b1;
    n = 0; g = 0; last_v = -1;
    while (n < 11 && g < 300) begin
      tick();
      g++;
      video_req = 1'b0;
      cpu_req = 1'b0;
      if (video_done) begin
        n++;
        if (last_v >= 0)
          check("t3_vid_gap", 32'((g - last_v) <= 10), 32'd1);
        last_v = g;
        if (n < 10) video_req = 1'b1;
      end
      if (cpu_done) begin
        n++;
        if (n < 10) cpu_req = 1'b1;
      end
    end
    check("t3_count", 32'(n), 32'd11);
    drain("t3_drain", 40);

    // Palette write (rd+wr together) racing a CPU read.
    w0 = wr_cnt;
    vd_in = 8'h5E;
    cpu_wr = 1'b0;
    cpu_addr = 19'h00123;
    up_addr = 19'h00040;
    up_wdata = 8'hC7;
    push(2'd1, 1'b1, 8'h5E);
    if (UP_WR == 1) push(2'd2, 1'b0, 8'h00);
    up_req_wr = 1'b1;
    up_req_rd = 1'b1;
    cpu_req = 1'b1;
    tick();
    up_req_wr = 1'b0;
    up_req_rd = 1'b0;
    cpu_req = 1'b0;
    drain("t4_drain", 40);
    check("t4_writes", 32'(wr_cnt - w0), 32'(UP_WR));
    if (UP_WR == 1) begin
      check("t4_wr_va", 32'(wr_va), 32'h00040);
      check("t4_wr_d", 32'(wr_d), 32'hC7);
    end

    // Reset during the second n_vwr-low cycle.
    cpu_wr = 1'b1;
    cpu_addr = 19'h05555;
    cpu_wdata = 8'h99;
    cpu_req = 1'b1;
    tick();
    cpu_req = 1'b0;
    tick();
    tick();
    tick();
    check("t5_in_write", 32'(n_vwr), 32'd0);
    usrrst_n = 1'b0;
    #1;
    check("t5_rst_strobes", 32'({n_vwr, vd_oe, n_vrd}), 32'b101);
    check("t5_rst_wait", 32'(cpu_wait), 32'd0);
    tick();
    tick();
    usrrst_n = 1'b1;
    repeat (6) tick();
    check("t5_no_done", 32'(sbq.size()), 32'd0);
    vd_in = 8'h2D;
    cpu_wr = 1'b0;
    cpu_addr = 19'h00777;
    push(2'd1, 1'b1, 8'h2D);
    cpu_req = 1'b1;
    tick();
    cpu_req = 1'b0;
    drain("t5_drain", 40);

    // Two CPU strobes before the grant collapse into one access.
    w0 = wr_cnt;
    vd_in = 8'h4B;
    video_addr = 19'h00AAA;
    push(2'd0, 1'b1, 8'h4B);
    push(2'd1, 1'b0, 8'h00);
    video_req = 1'b1;
    tick();
    video_req = 1'b0;
    cpu_wr = 1'b1;
    cpu_addr = 19'h01111;
    cpu_wdata = 8'h11;
    cpu_req = 1'b1;
    tick();
    cpu_addr = 19'h02222;
    cpu_wdata = 8'h22;
    tick();
    cpu_req = 1'b0;
    drain("t6_drain", 40);
    check("t6_writes", 32'(wr_cnt - w0), 32'd1);
    check("t6_wr_va", 32'(wr_va), 32'h02222);
    check("t6_wr_d", 32'(wr_d), 32'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
